keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// Keypad scanner for a 4x4 active-low matrix: drives one column low at a time,
// samples the synchronized rows, classifies each full scan frame and debounces
// presses/releases before reporting a digit key (0..9) or the set key (10).
module keypad_scan #(
   parameter int SCAN_DIV     = 4,
   parameter int DEBOUNCE_CNT = 3
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] keyValue,
   output logic       keySured,
   output logic       codeSet_t
);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_PRESS_DB   = 2'd1;
   localparam logic [1:0] ST_HELD       = 2'd2;
   localparam logic [1:0] ST_RELEASE_DB = 2'd3;

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
   localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CNT);

   logic [1:0]  rst_sync_q, rst_sync_d;
   logic [3:0]  row_s1_q, row_s2_q;
   logic [15:0] div_q, div_d;
   logic [1:0]  col_idx_q, col_idx_d;
   logic [3:0]  col_q, col_d;
   logic [15:0] samp_q, samp_d;
   logic [1:0]  state_q, state_d;
   logic [3:0]  cand_q, cand_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  key_q, key_d;
   logic        sured_q, sured_d;
   logic        set_q, set_d;

   logic        dwell_end;
   logic        frame_end;
   logic [4:0]  ones;
   logic [3:0]  code;
   logic        key_ok;
   logic [7:0]  cnt_inc;
   logic        cnt_hit;

   assign col       = col_q;
   assign keyValue  = key_q;
   assign keySured  = sured_q;
   assign codeSet_t = set_q;

   assign dwell_end = (div_q == DIV_LAST);
   assign frame_end = dwell_end && (col_idx_q == 2'd3);
   assign cnt_inc   = cnt_q + 8'd1;
   assign cnt_hit   = (cnt_inc == DB_LAST);

   // Column timing: divider per dwell, rotating one-cold column drive, and a
   // frame snapshot where bit r*4+c records "row r low while column c driven".
   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
      div_d      = div_q + 16'd1;
      col_idx_d  = col_idx_q;
      col_d      = col_q;
      samp_d     = samp_q;
      if (dwell_end) begin
         div_d     = 16'd0;
         col_idx_d = col_idx_q + 2'd1;
         col_d     = {col_q[2:0], col_q[3]};
         for (int c = 0; c < 4; c++) begin
            if (col_idx_q == 2'(c)) begin
               for (int r = 0; r < 4; r++) begin
                  samp_d[r*4 + c] = ~row_s2_q[r];
               end
            end
         end
      end
   end

   // Frame classification: exactly one low bit in the whole frame is a key;
   // anything else (none, multiple, or an unused code) is treated as no key.
   always_comb begin
      ones = 5'd0;
      code = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (samp_d[i]) begin
            ones = ones + 5'd1;
            code = 4'(i);
         end
      end
      key_ok = (ones == 5'd1) && (code <= 4'd10);
   end

   // Debounce FSM: advances only on frame boundaries once reset release has
   // been synchronized; outputs change in the same clock as the state.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      sured_d = sured_q;
      set_d   = set_q;
      if (frame_end && rst_sync_q[1]) begin
         case (state_q)
            ST_IDLE: begin
               if (key_ok) begin
                  cand_d = code;
                  if (DEBOUNCE_CNT == 1) begin
                     state_d = ST_HELD;
                     key_d   = code;
                     sured_d = (code <= 4'd9);
                     set_d   = (code == 4'd10);
                     cnt_d   = 8'd0;
                  end else begin
                     state_d = ST_PRESS_DB;
                     cnt_d   = 8'd1;
                  end
               end
            end
            ST_PRESS_DB: begin
               if (key_ok && code == cand_q) begin
                  if (cnt_hit) begin
                     state_d = ST_HELD;
                     key_d   = cand_q;
                     sured_d = (cand_q <= 4'd9);
                     set_d   = (cand_q == 4'd10);
                     cnt_d   = 8'd0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else if (key_ok) begin
                  cand_d = code;
                  cnt_d  = 8'd1;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = 8'd0;
               end
            end
            ST_HELD: begin
               if (!(key_ok && code == key_q)) begin
                  if (DEBOUNCE_CNT == 1) begin
                     state_d = ST_IDLE;
                     sured_d = 1'b0;
                     set_d   = 1'b0;
                     cnt_d   = 8'd0;
                  end else begin
                     state_d = ST_RELEASE_DB;
                     cnt_d   = 8'd1;
                  end
               end
            end
            default: begin
               if (key_ok && code == key_q) begin
                  state_d = ST_HELD;
                  cnt_d   = 8'd0;
               end else if (cnt_hit) begin
                  state_d = ST_IDLE;
                  sured_d = 1'b0;
                  set_d   = 1'b0;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         endcase
      end
   end

   // State registers; the row synchronizer and reset synchronizer live here too.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rst_sync_q <= 2'b00;
         row_s1_q   <= 4'h0;
         row_s2_q   <= 4'h0;
         div_q      <= 16'd0;
         col_idx_q  <= 2'd0;
         col_q      <= 4'b1110;
         samp_q     <= 16'h0000;
         state_q    <= ST_IDLE;
         cand_q     <= 4'd0;
         cnt_q      <= 8'd0;
         key_q      <= 4'd0;
         sured_q    <= 1'b0;
         set_q      <= 1'b0;
      end else begin
         rst_sync_q <= rst_sync_d;
         row_s1_q   <= row;
         row_s2_q   <= row_s1_q;
         div_q      <= div_d;
         col_idx_q  <= col_idx_d;
         col_q      <= col_d;
         samp_q     <= samp_d;
         state_q    <= state_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         key_q      <= key_d;
         sured_q    <= sured_d;
         set_q      <= set_d;
      end
   end

endmodule
